// File: rtl/led_drv_pkg.sv
// ---------------------------------------------------------------------------
// led_drv_pkg
// Shared definitions for the LED channel driver: channel mode encoding and
// the prescaler reload helper used to derive the base tick.
// ---------------------------------------------------------------------------
package led_drv_pkg;

  // Channel operating modes; the encoding matches the cfg_mode write field.
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_e;

  // Prescaler reload value: the tick fires once every reload+1 clocks.
  function automatic int presc_reload(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz - 1;
  endfunction

endpackage

// File: rtl/led_channel.sv
// ---------------------------------------------------------------------------
// led_channel
// State for one LED channel: mode, period, duty, period counter, blink phase
// and breathe level/direction. Produces the unregistered "lit" request that
// the top registers onto the pin.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   tick_i        one-cycle base tick from the shared prescaler
//   pwm_cnt_i     shared free-running PWM counter
//   wr_i          write strobe (accepted write addressed to this channel)
//   mode_i        new mode
//   period_i      new blink half-period / breathe step interval, in ticks
//   duty_i        new brightness or breathe ceiling
//   lit_o         1 = LED should be lit this cycle
// ---------------------------------------------------------------------------
module led_channel
  import led_drv_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int PERIOD_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick_i,
  input  logic [PWM_BITS-1:0]    pwm_cnt_i,
  input  logic                   wr_i,
  input  logic [1:0]             mode_i,
  input  logic [PERIOD_BITS-1:0] period_i,
  input  logic [PWM_BITS-1:0]    duty_i,
  output logic                   lit_o
);

  led_mode_e              mode_q, mode_d;
  logic [PERIOD_BITS-1:0] period_q, period_d;
  logic [PWM_BITS-1:0]    duty_q, duty_d;
  logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic                   phase_q, phase_d;
  logic [PWM_BITS-1:0]    level_q, level_d;
  logic                   dir_down_q, dir_down_d;

  // Counter reload value: a period of 0 behaves like a period of 1.
  function automatic logic [PERIOD_BITS-1:0] reload_of(input logic [PERIOD_BITS-1:0] p);
    return (p == '0) ? '0 : p - PERIOD_BITS'(1);
  endfunction

  // All-ones duty is forced fully on; otherwise a plain compare.
  function automatic logic pwm_on(input logic [PWM_BITS-1:0] d,
                                  input logic [PWM_BITS-1:0] cnt);
    return (d == '1) | (cnt < d);
  endfunction

  always_comb begin
    mode_d     = mode_q;
    period_d   = period_q;
    duty_d     = duty_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    level_d    = level_q;
    dir_down_d = dir_down_q;
    if (wr_i) begin
      // A write always restarts the channel, and overrides a coincident tick.
      mode_d     = led_mode_e'(mode_i);
      period_d   = period_i;
      duty_d     = duty_i;
      cnt_d      = reload_of(period_i);
      phase_d    = 1'b1;
      level_d    = '0;
      dir_down_d = 1'b0;
    end else if (tick_i && (mode_q == MODE_BLINK || mode_q == MODE_BREATHE)) begin
      if (cnt_q == '0) begin
        cnt_d = reload_of(period_q);
        if (mode_q == MODE_BLINK) begin
          phase_d = ~phase_q;
        end else if (!dir_down_q) begin
          // At the ceiling, turn around but hold the level for this step.
          if (level_q == duty_q) dir_down_d = 1'b1;
          else                   level_d    = level_q + PWM_BITS'(1);
        end else begin
          // At zero, turn around but hold the level for this step.
          if (level_q == '0) dir_down_d = 1'b0;
          else               level_d    = level_q - PWM_BITS'(1);
        end
      end else begin
        cnt_d = cnt_q - PERIOD_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_OFF;
      period_q   <= '0;
      duty_q     <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b1;
      level_q    <= '0;
      dir_down_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      period_q   <= period_d;
      duty_q     <= duty_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      level_q    <= level_d;
      dir_down_q <= dir_down_d;
    end
  end

  always_comb begin
    lit_o = 1'b0;
    unique case (mode_q)
      MODE_OFF:     lit_o = 1'b0;
      MODE_ON:      lit_o = pwm_on(duty_q, pwm_cnt_i);
      MODE_BLINK:   lit_o = phase_q & pwm_on(duty_q, pwm_cnt_i);
      MODE_BREATHE: lit_o = pwm_on(level_q, pwm_cnt_i);
      default:      lit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_channel_driver.sv
// ---------------------------------------------------------------------------
// led_channel_driver
// N-channel LED driver: shared tick prescaler and PWM counter, per-channel
// OFF/ON/BLINK/BREATHE modes configured through a valid/ready write port.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   cfg_valid    config write request
//   cfg_ready    config accept (high from the first cycle after reset)
//   cfg_chan     target channel
//   cfg_mode     0 OFF, 1 ON, 2 BLINK, 3 BREATHE
//   cfg_period   blink half-period / breathe step interval, in ticks
//   cfg_duty     brightness (ON/BLINK) or breathe ceiling
//   cfg_err      one-cycle pulse after a write to a nonexistent channel
//   tick         one-cycle pulse at TICK_HZ
//   led_out      registered LED pins, polarity per ACTIVE_LOW
// ---------------------------------------------------------------------------
module led_channel_driver
  import led_drv_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int CLK_HZ      = 12000000,
  parameter int TICK_HZ     = 1000,
  parameter int PWM_BITS    = 8,
  parameter int PERIOD_BITS = 16,
  parameter int ACTIVE_LOW  = 1,
  localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CW-1:0]          cfg_chan,
  input  logic [1:0]             cfg_mode,
  input  logic [PERIOD_BITS-1:0] cfg_period,
  input  logic [PWM_BITS-1:0]    cfg_duty,
  output logic                   cfg_err,
  output logic                   tick,
  output logic [CHANNELS-1:0]    led_out
);

  localparam int RELOAD  = presc_reload(CLK_HZ, TICK_HZ);
  localparam int PRESC_W = (RELOAD > 1) ? $clog2(RELOAD + 1) : 1;
  // Pin level of an unlit LED; also the reset value of the pins.
  localparam logic [CHANNELS-1:0] LED_DARK = (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : '0;

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                tick_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                ready_q;
  logic                err_q;
  logic [CHANNELS-1:0] led_q;
  logic [CHANNELS-1:0] lit;
  logic                accept;
  logic                chan_ok;

  assign accept  = cfg_valid & ready_q;
  assign chan_ok = {{(32-CW){1'b0}}, cfg_chan} < 32'(CHANNELS);
  assign presc_d = (presc_q == '0) ? PRESC_W'(RELOAD) : presc_q - PRESC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= PRESC_W'(RELOAD);
      tick_q    <= 1'b0;
      pwm_cnt_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      led_q     <= LED_DARK;
    end else begin
      presc_q   <= presc_d;
      tick_q    <= (presc_q == '0);
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      ready_q   <= 1'b1;
      err_q     <= accept & ~chan_ok;
      led_q     <= lit ^ LED_DARK;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    led_channel #(
      .PWM_BITS   (PWM_BITS),
      .PERIOD_BITS(PERIOD_BITS)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick_q),
      .pwm_cnt_i(pwm_cnt_q),
      .wr_i     (accept && (cfg_chan == CW'(gi))),
      .mode_i   (cfg_mode),
      .period_i (cfg_period),
      .duty_i   (cfg_duty),
      .lit_o    (lit[gi])
    );
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  assign tick      = tick_q;
  assign led_out   = led_q;

endmodule

// File: tb/tb_led_channel_driver.sv
// ---------------------------------------------------------------------------
// tb_led_channel_driver
// Self-checking bench for led_channel_driver (3 channels, 100 Hz clock model,
// 10 Hz tick, active-low pins). A reference model derives every expected pin
// value from the time of each channel's last write: the number of ticks seen
// since then gives the number of period expiries, from which blink phase and
// breathe level follow arithmetically.
// ---------------------------------------------------------------------------
module tb_led_channel_driver;

  localparam int CH  = 3;
  localparam int DIV = 10;   // clocks per tick

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_chan = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_period = '0;
  logic [7:0]  cfg_duty = '0;
  logic        cfg_err;
  logic        tick;
  logic [2:0]  led_out;

  led_channel_driver #(
    .CHANNELS   (CH),
    .CLK_HZ     (100),
    .TICK_HZ    (10),
    .PWM_BITS   (8),
    .PERIOD_BITS(16),
    .ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_mode  (cfg_mode),
    .cfg_period(cfg_period),
    .cfg_duty  (cfg_duty),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: n = clock edges since reset release.
  int n = 0;
  int w_edge [CH];
  int m_mode [CH];
  int m_per  [CH];
  int m_duty [CH];
  logic [2:0] exp_led;
  logic       exp_tick, exp_err, exp_ready;

  // Number of tick-consuming edges at or before edge x (edges 11, 21, ...).
  function automatic int ticks_upto(input int x);
    return (x >= 1) ? (x - 1) / DIV : 0;
  endfunction

  function automatic bit pwm_on(input int d, input int p);
    return (d == 255) || (p < d);
  endfunction

  // Whether channel ch is lit in the state reached after edge m.
  function automatic bit model_lit(input int ch, input int m);
    int p, t, eff, e, k, lvl, d;
    p   = m % 256;
    d   = m_duty[ch];
    t   = ticks_upto(m) - ticks_upto(w_edge[ch]);
    eff = (m_per[ch] == 0) ? 1 : m_per[ch];
    e   = t / eff;
    case (m_mode[ch])
      1: return pwm_on(d, p);
      2: return (e % 2 == 0) && pwm_on(d, p);
      3: begin
        // Triangle 0..d, d..0 with one repeated value at each end.
        k   = e % (2 * d + 2);
        lvl = (k <= d) ? k : (2 * d + 1 - k);
        return pwm_on(lvl, p);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  // One clock: update the model at the edge, compare all outputs mid-cycle.
  task automatic step();
    bit acc;
    @(posedge clk);
    if (rst) begin
      n = 0;
      for (int c = 0; c < CH; c++) m_mode[c] = 0;
      exp_led   = 3'b111;
      exp_tick  = 1'b0;
      exp_err   = 1'b0;
      exp_ready = 1'b0;
    end else begin
      n++;
      for (int c = 0; c < CH; c++) exp_led[c] = ~model_lit(c, n - 1);
      exp_tick  = (n % DIV == 0);
      exp_ready = 1'b1;
      acc       = cfg_valid && (n >= 2);
      exp_err   = acc && (cfg_chan >= 2'(CH));
      if (acc && cfg_chan < 2'(CH)) begin
        w_edge[cfg_chan] = n;
        m_mode[cfg_chan] = int'(cfg_mode);
        m_per[cfg_chan]  = int'(cfg_period);
        m_duty[cfg_chan] = int'(cfg_duty);
      end
    end
    @(negedge clk);
    check("led_out", 32'(led_out), 32'(exp_led));
    check("tick", 32'(tick), 32'(exp_tick));
    check("cfg_err", 32'(cfg_err), 32'(exp_err));
    check("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic do_write(input int ch, input int mode, input int per, input int duty);
    cfg_chan   = 2'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = 16'(per);
    cfg_duty   = 8'(duty);
    cfg_valid  = 1'b1;
    step();
    cfg_valid  = 1'b0;
    $display("[TB] write chan=%0d mode=%0d period=%0d duty=%0d edge=%0d", ch, mode, per, duty, n);
  endtask

  // Counts clocks until tick is seen, bounded; -1 if it never arrives.
  task automatic tick_latency(output int lat);
    lat = -1;
    for (int j = 1; j <= 30; j++) begin
      step();
      if (tick === 1'b1) begin
        lat = j;
        break;
      end
    end
  endtask

  typedef struct {
    int chan;
    int mode;
    int per;
    int duty;
    int window;   // clocks to observe after the write
    int exp_lit;  // lit clocks expected on chan within the window
    bit exp_err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int lat, lit_cnt;
    bit found;

    for (int c = 0; c < CH; c++) begin
      w_edge[c] = 0; m_mode[c] = 0; m_per[c] = 0; m_duty[c] = 0;
    end

    vecs[0] = '{0, 1,   0, 255, 256, 256, 1'b0};  // ON full
    vecs[1] = '{0, 1,   0,  64, 256,  64, 1'b0};  // ON quarter
    vecs[2] = '{0, 1,   0,   0, 256,   0, 1'b0};  // ON duty 0 is dark
    vecs[3] = '{0, 1,   0,   1, 256,   1, 1'b0};  // ON minimum duty
    vecs[4] = '{1, 2,   3, 255,  60,  30, 1'b0};  // BLINK 3 ticks on/off
    vecs[5] = '{1, 2,   0, 255,  20,  10, 1'b0};  // BLINK period 0 = 1
    vecs[6] = '{2, 3,  30,   3, 256,   0, 1'b0};  // BREATHE starts at level 0
    vecs[7] = '{2, 3,   1,   0, 200,   0, 1'b0};  // BREATHE duty 0 stays dark
    vecs[8] = '{2, 0,   0, 255, 100,   0, 1'b0};  // OFF
    vecs[9] = '{3, 1,   0, 255,   0,   0, 1'b1};  // nonexistent channel

    // Reset and first tick.
    rst = 1'b1;
    run(3);
    check("reset led_out", 32'(led_out), 32'h7);
    check("reset cfg_ready", 32'(cfg_ready), 32'h0);
    rst = 1'b0;
    tick_latency(lat);
    check("first tick latency", lat, 10);
    run(5);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      do_write(vecs[i].chan, vecs[i].mode, vecs[i].per, vecs[i].duty);
      check("vec err", 32'(cfg_err), 32'(vecs[i].exp_err));
      lit_cnt = 0;
      for (int j = 0; j < vecs[i].window; j++) begin
        step();
        if (led_out[vecs[i].chan] === 1'b0) lit_cnt++;
      end
      if (vecs[i].window > 0) check("vec lit count", lit_cnt, vecs[i].exp_lit);
      run(3);
    end

    // Write landing on the same edge as a tick on a blinking channel.
    do_write(1, 2, 2, 255);
    run(50);
    found = 1'b0;
    for (int j = 0; j < 25; j++) begin
      step();
      if (tick === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("tick before coincident write", 32'(found), 32'h1);
    do_write(1, 2, 2, 255);
    lit_cnt = 0;
    for (int j = 0; j < 100; j++) begin
      step();
      if (led_out[1] === 1'b0) lit_cnt++;
      else break;
    end
    check("blink lit span after write on tick", lit_cnt, 20);

    // Reset in the middle of breathing.
    do_write(2, 3, 1, 3);
    do_write(0, 1, 0, 255);
    run(120);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid reset led_out", 32'(led_out), 32'h7);
    tick_latency(lat);
    check("tick latency after mid reset", lat, 10);
    run(20);
    check("channels off after reset", 32'(led_out), 32'h7);

    // Randomised writes against the model.
    for (int i = 0; i < 60; i++) begin
      int ch, md, pr, dt;
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      ch = int'($urandom_range(0, 3));
      md = int'($urandom_range(0, 3));
      pr = int'($urandom_range(0, 4));
      case ($urandom_range(0, 3))
        0: dt = 0;
        1: dt = 255;
        2: dt = int'($urandom_range(0, 5));
        default: dt = int'($urandom_range(0, 255));
      endcase
      do_write(ch, md, pr, dt);
      run(int'($urandom_range(0, 300)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
